// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file sequencer and its ALU.
// SHIFT_EN (optional define) enables the operand-B shifter in regfile_seq.
package regfile_seq_pkg;

  localparam int W_DEFAULT = 16;

  // 3'b110 and 3'b111 are illegal and deliberately left unnamed
  typedef enum logic [2:0] {
    OP_MOVI = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_CMP  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVN  = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_EXEC,
    S_WB,
    S_ERR
  } state_e;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/alu16.sv
// Combinational ALU for regfile_seq: result plus zero/negative/overflow.
// CMP produces A-B on result so its flags can be taken; the caller discards it.
module alu16
  import regfile_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] result,
  output logic         z,
  output logic         n,
  output logic         v
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = b;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        v      = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_CMP: begin
        result = diff;
        v      = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND:  result = a & b;
      OP_MVN:  result = ~b;
      default: result = b;
    endcase
    z = (result == '0);
    n = result[W-1];
  end

endmodule

// File: rtl/regfile_seq.sv
// Sequencer driving an 8xW single-port register file: read operands, execute, write back.
// SHIFT_EN (optional define) shifts operand B as it is captured in RDB.
//
// state | meaning
// IDLE  | w=1, waiting for s
// RDA   | readnum=rn, capture A
// RDB   | readnum=rm, capture (optionally shifted) B
// EXEC  | C<=ALU(A,B), ADD/CMP update flags; CMP finishes here
// WB    | write C (or sign-extended imm) to rd, done
// ERR   | illegal opcode, done without write
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [2:0]       in_op,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rn,
  input  logic [2:0]       in_rm,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [1:0]       in_sh,
  output logic             w,
  output logic             done,
  output logic [2:0]       rf_readnum,
  output logic [2:0]       rf_writenum,
  output logic             rf_write,
  output logic [W-1:0]     rf_data_in,
  input  logic [W-1:0]     rf_data_out,
  output logic             Z,
  output logic             N,
  output logic             V
);

  state_e state_q, state_d;

  logic [2:0]       op_q, rd_q, rn_q, rm_q;
  logic [IMM_W-1:0] imm_q;
  logic [1:0]       sh_q;
  logic [W-1:0]     a_q, b_q, c_q;
  logic [W-1:0]     b_shift, imm_ext;
  logic [W-1:0]     alu_res;
  logic             alu_z, alu_n, alu_v;

  assign imm_ext = {{(W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

`ifdef SHIFT_EN
  always_comb begin
    b_shift = rf_data_out;
    case (sh_q)
      SH_LSL1: b_shift = {rf_data_out[W-2:0], 1'b0};
      SH_LSR1: b_shift = {1'b0, rf_data_out[W-1:1]};
      SH_ASR1: b_shift = {rf_data_out[W-1], rf_data_out[W-1:1]};
      default: b_shift = rf_data_out;
    endcase
  end
`else
  logic unused_sh;
  assign unused_sh = ^sh_q;
  assign b_shift   = rf_data_out;
`endif

  alu16 #(.W(W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .z      (alu_z),
    .n      (alu_n),
    .v      (alu_v)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    w           = 1'b0;
    done        = 1'b0;
    rf_readnum  = 3'd0;
    rf_writenum = 3'd0;
    rf_write    = 1'b0;
    rf_data_in  = '0;
    case (state_q)
      S_IDLE: begin
        w = 1'b1;
        if (s) begin
          case (in_op)
            OP_MOVI:                state_d = S_WB;
            OP_MOV, OP_MVN:         state_d = S_RDB;
            OP_ADD, OP_CMP, OP_AND: state_d = S_RDA;
            default:                state_d = S_ERR;
          endcase
        end
      end
      S_RDA: begin
        rf_readnum = rn_q;
        state_d    = S_RDB;
      end
      S_RDB: begin
        rf_readnum = rm_q;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_CMP) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = (op_q == OP_MOVI) ? imm_ext : c_q;
        done        = 1'b1;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      rd_q  <= '0;
      rn_q  <= '0;
      rm_q  <= '0;
      imm_q <= '0;
      sh_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      Z     <= 1'b0;
      N     <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (s) begin
            op_q  <= in_op;
            rd_q  <= in_rd;
            rn_q  <= in_rn;
            rm_q  <= in_rm;
            imm_q <= in_imm;
            sh_q  <= in_sh;
          end
        end
        S_RDA: a_q <= rf_data_out;
        S_RDB: b_q <= b_shift;
        S_EXEC: begin
          if (op_q != OP_CMP) c_q <= alu_res;
          if (op_q == OP_ADD || op_q == OP_CMP) begin
            Z <= alu_z;
            N <= alu_n;
            V <= alu_v;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq with an 8x16 register file model and a
// reference model of the instruction set computed with plain integer arithmetic.
`timescale 1ns/1ps
module tb_regfile_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [2:0]  in_op, in_rd, in_rn, in_rm;
  logic [7:0]  in_imm;
  logic [1:0]  in_sh;
  logic        w, done;
  logic [2:0]  rf_readnum, rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in, rf_data_out;
  logic        Z, N, V;

  logic [15:0] rf_mem [8];
  logic        tb_we;
  logic [2:0]  tb_waddr;
  logic [15:0] tb_wdata;

  logic [15:0] ref_regs [8];
  logic        ref_z, ref_n, ref_v;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_seq dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rn       (in_rn),
    .in_rm       (in_rm),
    .in_imm      (in_imm),
    .in_sh       (in_sh),
    .w           (w),
    .done        (done),
    .rf_readnum  (rf_readnum),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out),
    .Z           (Z),
    .N           (N),
    .V           (V)
  );

  // register file: combinational read, clocked write; bench port used only for preload
  assign rf_data_out = rf_mem[rf_readnum];
  always @(posedge clk) begin
    if (rf_write)   rf_mem[rf_writenum] <= rf_data_in;
    else if (tb_we) rf_mem[tb_waddr]    <= tb_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] shift_b(input logic [15:0] b, input logic [1:0] sh);
`ifdef SHIFT_EN
    case (sh)
      2'b01:   return b << 1;
      2'b10:   return b >> 1;
      2'b11:   return 16'($signed(b) >>> 1);
      default: return b;
    endcase
`else
    logic [1:0] unused_sh;
    unused_sh = sh;
    return b;
`endif
  endfunction

  // Reference: what the instruction must do, and how many cycles until done.
  task automatic model_exec(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                            input logic [2:0] rm, input logic [7:0] imm, input logic [1:0] sh,
                            output int lat, output bit wr, output logic [15:0] wr_val);
    logic [15:0] a, b;
    int sa, sb, si, res;
    a  = ref_regs[rn];
    b  = shift_b(ref_regs[rm], sh);
    sa = $signed(a);
    sb = $signed(b);
    si = $signed(imm);
    wr = 1'b0;
    wr_val = 16'h0;
    case (op)
      3'd0: begin lat = 1; wr = 1'b1; wr_val = 16'(si); end
      3'd1: begin lat = 3; wr = 1'b1; wr_val = b; end
      3'd2: begin
        lat = 4; wr = 1'b1; res = sa + sb; wr_val = 16'(res);
        ref_z = (wr_val == 16'h0); ref_n = wr_val[15]; ref_v = (res > 32767) || (res < -32768);
      end
      3'd3: begin
        logic [15:0] d;
        lat = 3; res = sa - sb; d = 16'(res);
        ref_z = (d == 16'h0); ref_n = d[15]; ref_v = (res > 32767) || (res < -32768);
      end
      3'd4: begin lat = 4; wr = 1'b1; wr_val = a & b; end
      3'd5: begin lat = 3; wr = 1'b1; wr_val = ~b; end
      default: lat = 1;
    endcase
    if (wr) ref_regs[rd] = wr_val;
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
    tb_we = 1'b1; tb_waddr = idx; tb_wdata = val;
    @(posedge clk);
    @(negedge clk);
    tb_we = 1'b0;
    ref_regs[idx] = val;
  endtask

  // Issue one instruction from a negedge; optionally pulse s while busy.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rn, input logic [2:0] rm, input logic [7:0] imm,
                           input logic [1:0] sh, input bit poke);
    int lat, cyc, stray;
    bit wr, got;
    logic [15:0] wval;
    logic [2:0] rd_seq [4];
    cyc = 0;
    while (w !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    vectors++;
    if (w !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle_wait: w=%b required 1 within 20 cycles", tag, w);
    end
    model_exec(op, rd, rn, rm, imm, sh, lat, wr, wval);
    in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_sh = sh; s = 1'b1;
    got = 1'b0; stray = 0;
    for (cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc <= 4) rd_seq[cyc-1] = rf_readnum;
      if (cyc == 1) begin
        s = poke;
        if (poke) begin in_op = 3'd0; in_rd = 3'd0; in_imm = 8'h55; end
      end
      if (cyc == 2) s = 1'b0;
      if (done === 1'b1) begin got = 1'b1; break; end
      if (rf_write !== 1'b0) stray++;
    end
    s = 1'b0;
    vectors++;
    if (!got || cyc != lat) begin
      miscompares++;
      $display("FAIL %s latency: done after %0d cycles (seen=%0b), required %0d", tag, cyc, got, lat);
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL %s early_write: %0d write cycles before done, required 0", tag, stray);
    end
    vectors++;
    if (rf_write !== wr) begin
      miscompares++;
      $display("FAIL %s write_en: rf_write=%b at done, required %b", tag, rf_write, wr);
    end
    if (wr) begin
      vectors++;
      if (rf_writenum !== rd || rf_data_in !== wval) begin
        miscompares++;
        $display("FAIL %s write_data: R%0d<=%h, required R%0d<=%h", tag, rf_writenum, rf_data_in, rd, wval);
      end
    end
    if (got && (op == 3'd2 || op == 3'd3 || op == 3'd4)) begin
      vectors++;
      if (rd_seq[0] !== rn || rd_seq[1] !== rm) begin
        miscompares++;
        $display("FAIL %s readnum: %0d,%0d required %0d,%0d", tag, rd_seq[0], rd_seq[1], rn, rm);
      end
    end else if (got && (op == 3'd1 || op == 3'd5)) begin
      vectors++;
      if (rd_seq[0] !== rm) begin
        miscompares++;
        $display("FAIL %s readnum: %0d required %0d", tag, rd_seq[0], rm);
      end
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (w !== 1'b1) begin
      miscompares++;
      $display("FAIL %s return_idle: w=%b required 1", tag, w);
    end
    vectors++;
    if ({Z, N, V} !== {ref_z, ref_n, ref_v}) begin
      miscompares++;
      $display("FAIL %s flags: ZNV=%b%b%b required %b%b%b", tag, Z, N, V, ref_z, ref_n, ref_v);
    end
    vectors++;
    if (rf_mem[rd] !== ref_regs[rd]) begin
      miscompares++;
      $display("FAIL %s regfile: R%0d=%h required %h", tag, rd, rf_mem[rd], ref_regs[rd]);
    end
    if (poke) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || w !== 1'b1) begin
        miscompares++;
        $display("FAIL %s s_ignored: done=%b w=%b, required done=0 w=1", tag, done, w);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; tb_we = 1'b0; tb_waddr = 3'd0; tb_wdata = 16'h0;
    in_op = 3'd0; in_rd = 3'd0; in_rn = 3'd0; in_rm = 3'd0; in_imm = 8'h0; in_sh = 2'b00;
    ref_z = 1'b0; ref_n = 1'b0; ref_v = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({w, done, rf_write, rf_readnum, rf_writenum, rf_data_in, Z, N, V} !== {3'b100, 6'd0, 16'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_values: w=%b done=%b wr=%b rn=%0d wn=%0d din=%h ZNV=%b%b%b, required w=1 rest 0",
               w, done, rf_write, rf_readnum, rf_writenum, rf_data_in, Z, N, V);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (w !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: w=%b done=%b required 1/0", w, done);
    end
    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));
  endtask

  task automatic test_movi();
    run_instr("movi", 3'd0, 3'd3, 3'd0, 3'd0, 8'hF0, 2'b00, 1'b0);
    vectors++;
    if (rf_mem[3] !== 16'hFFF0) begin
      miscompares++;
      $display("FAIL movi_value: R3=%h required fff0", rf_mem[3]);
    end
  endtask

  task automatic test_add_overflow();
    set_reg(3'd1, 16'h7FFF);
    set_reg(3'd2, 16'h0001);
    run_instr("add_ovf", 3'd2, 3'd4, 3'd1, 3'd2, 8'h00, 2'b00, 1'b0);
    vectors++;
    if (rf_mem[4] !== 16'h8000 || {Z, N, V} !== 3'b011) begin
      miscompares++;
      $display("FAIL add_ovf_value: R4=%h ZNV=%b%b%b required 8000 011", rf_mem[4], Z, N, V);
    end
  endtask

  task automatic test_cmp_equal();
    set_reg(3'd5, 16'h1234);
    run_instr("cmp_eq", 3'd3, 3'd0, 3'd5, 3'd5, 8'h00, 2'b00, 1'b0);
    vectors++;
    if ({Z, N, V} !== 3'b100) begin
      miscompares++;
      $display("FAIL cmp_eq_flags: ZNV=%b%b%b required 100", Z, N, V);
    end
  endtask

  task automatic test_reset_mid();
    set_reg(3'd4, 16'hAAAA);
    in_op = 3'd2; in_rd = 3'd4; in_rn = 3'd1; in_rm = 3'd2; in_sh = 2'b00; s = 1'b1;
    @(posedge clk); @(negedge clk);
    s = 1'b0;
    @(posedge clk); @(negedge clk);
    #1 reset = 1'b1;
    #1;
    ref_z = 1'b0; ref_n = 1'b0; ref_v = 1'b0;
    vectors++;
    if (w !== 1'b1 || rf_write !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: w=%b rf_write=%b done=%b required 1/0/0", w, rf_write, done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rf_mem[4] !== 16'hAAAA || {Z, N, V} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_discard: R4=%h ZNV=%b%b%b required aaaa 000", rf_mem[4], Z, N, V);
    end
    run_instr("after_reset", 3'd5, 3'd0, 3'd0, 3'd4, 8'h00, 2'b00, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 3'd7, 3'd6, 3'd1, 3'd2, 8'h12, 2'b00, 1'b0);
    run_instr("illegal6", 3'd6, 3'd3, 3'd1, 3'd2, 8'h34, 2'b00, 1'b0);
    run_instr("busy_poke", 3'd2, 3'd5, 3'd3, 3'd4, 8'h00, 2'b00, 1'b1);
  endtask

  task automatic test_shift_mov();
    set_reg(3'd2, 16'h8001);
    run_instr("shift_mov", 3'd1, 3'd6, 3'd0, 3'd2, 8'h00, 2'b11, 1'b0);
    vectors++;
`ifdef SHIFT_EN
    if (rf_mem[6] !== 16'hC000) begin
      miscompares++;
      $display("FAIL shift_mov_value: R6=%h required c000", rf_mem[6]);
    end
`else
    if (rf_mem[6] !== 16'h8001) begin
      miscompares++;
      $display("FAIL shift_mov_value: R6=%h required 8001", rf_mem[6]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat, dones;
    bit wr;
    logic [15:0] wval;
    set_reg(3'd7, 16'h0001);
    set_reg(3'd1, 16'h0003);
    model_exec(3'd2, 3'd7, 3'd7, 3'd1, 8'h00, 2'b00, lat, wr, wval);
    model_exec(3'd2, 3'd7, 3'd7, 3'd1, 8'h00, 2'b00, lat, wr, wval);
    in_op = 3'd2; in_rd = 3'd7; in_rn = 3'd7; in_rm = 3'd1; in_sh = 2'b00; s = 1'b1;
    dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) dones++;
      if (i == 10) s = 1'b0;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (dones != 2) begin
      miscompares++;
      $display("FAIL b2b_count: %0d done pulses in 10 cycles, required 2", dones);
    end
    vectors++;
    if (rf_mem[7] !== ref_regs[7] || {Z, N, V} !== {ref_z, ref_n, ref_v}) begin
      miscompares++;
      $display("FAIL b2b_result: R7=%h ZNV=%b%b%b required %h %b%b%b",
               rf_mem[7], Z, N, V, ref_regs[7], ref_z, ref_n, ref_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) set_reg(3'($urandom_range(0, 7)), 16'($urandom));
      run_instr("random", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom),
                2'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_movi();
    test_add_overflow();
    test_cmp_equal();
    test_reset_mid();
    test_illegal();
    test_shift_mov();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
